mc_mem_unit: RTL and testbench

Memory responder for the multicycle MIPS core: accepts access requests from the main control FSM, holds the unified instruction/data memory, the Instruction Register (IR) and the Memory Data Register (MDR), and signals completion with a one-cycle `ready` pulse. Sits between the controller/datapath and storage, so the controller can tolerate configurable memory wait states instead of assuming single-cycle memory.

---
 rtl/mc_pkg.sv | 16 +
 rtl/mc_mem_unit_if.sv | 30 +++
 rtl/mc_mem_array.sv | 22 ++
 rtl/mc_mem_unit.sv | 106 ++++++++++
 tb/tb_mc_mem_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS memory slice.
// Holds the responder FSM state type, word width and opcodes.
package mc_pkg;

    localparam int WORD_W = 32;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } mem_state_t;

endpackage

// File: rtl/mc_mem_unit_if.sv
// Controller <-> memory responder bundle.
// master = main control FSM / datapath, slave = mc_mem_unit.
interface mc_mem_unit_if
    import mc_pkg::*;
();
    logic              req;
    logic              iord;
    logic              memwrite;
    logic              irwrite;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] aluout;
    logic [WORD_W-1:0] wd;
    logic              ready;
    logic              busy;
    logic              err;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] mdr;

    modport master (
        output req, iord, memwrite, irwrite,
        output pc, aluout, wd,
        input  ready, busy, err, instr, mdr
    );

    modport slave (
        input  req, iord, memwrite, irwrite,
        input  pc, aluout, wd,
        output ready, busy, err, instr, mdr
    );
endinterface

// File: rtl/mc_mem_array.sv
// Single-port DEPTH x 32 storage; contents are never reset.
// Read word is captured into IR/MDR by the owner on the access edge.
module mc_mem_array
    import mc_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);
    logic [WORD_W-1:0] mem [DEPTH];

    // Write port: one word per enabled edge.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/mc_mem_unit.sv
// Memory responder: FSM, wait counter, address mux, IR and MDR.
// Optional MC_MEM_ALIGN_CHK_EN blocks misaligned accesses and flags err.
module mc_mem_unit
    import mc_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    mc_mem_unit_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    mem_state_t        state_q, state_d;
    logic [3:0]        cnt_q;
    logic [AW+1:0]     addr_q;
    logic [WORD_W-1:0] wd_q;
    logic              mw_q, irw_q;
    logic              ready_q, err_q;
    logic [WORD_W-1:0] ir_q, mdr_q;
    logic [WORD_W-1:0] addr_in, rdata;
    logic              accept, access, ok, we, rd;
    logic              unused_hi;

    assign addr_in   = bus.iord ? bus.aluout : bus.pc;
    assign unused_hi = ^addr_in[WORD_W-1:AW+2];

`ifdef MC_MEM_ALIGN_CHK_EN
    assign ok = (addr_q[1:0] == 2'b00);
`else
    logic unused_lo;
    assign unused_lo = ^addr_q[1:0];
    assign ok        = 1'b1;
`endif

    assign accept = (state_q == IDLE) && bus.req;
    assign access = (state_q == WAIT) && (cnt_q == 4'd0);
    assign we     = access && mw_q && ok;
    assign rd     = access && !mw_q && ok;

    mc_mem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (we),
        .addr  (addr_q[AW+1:2]),
        .wdata (wd_q),
        .rdata (rdata)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: accept in IDLE, count down, single DONE cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.req) state_d = WAIT;
            WAIT:    if (cnt_q == 4'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch request controls on accept and run the wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 4'd0;
            addr_q <= '0;
            wd_q   <= '0;
            mw_q   <= 1'b0;
            irw_q  <= 1'b0;
        end else if (accept) begin
            cnt_q  <= 4'(WAIT_CYCLES);
            addr_q <= addr_in[AW+1:0];
            wd_q   <= bus.wd;
            mw_q   <= bus.memwrite;
            irw_q  <= bus.irwrite;
        end else if (state_q == WAIT && cnt_q != 4'd0) begin
            cnt_q  <= cnt_q - 4'd1;
        end
    end

    // Completion flags and IR/MDR capture on the access edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            ir_q    <= '0;
            mdr_q   <= '0;
        end else begin
            ready_q <= access;
            err_q   <= access && !ok;
            if (rd)          mdr_q <= rdata;
            if (rd && irw_q) ir_q  <= rdata;
        end
    end

    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.instr = ir_q;
    assign bus.mdr   = mdr_q;
endmodule

// File: tb/tb_mc_mem_unit.sv
// Scoreboard bench for mc_mem_unit against a word-array model.
// Honours MC_MEM_ALIGN_CHK_EN when computing expected results.
module tb_mc_mem_unit;
    import mc_pkg::*;

    localparam int DEPTH = 256;
    localparam int W     = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_mem_unit_if bus();

    mc_mem_unit #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        err;
        logic [31:0] instr;
        logic [31:0] mdr;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_ir  = '0;
    logic [31:0] m_mdr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: word-addressed memory, addresses wrap modulo DEPTH*4.
    task automatic model(input bit mw, input bit irw,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output bit e);
        int idx;
        idx = int'((addr >> 2) % DEPTH);
        e   = 1'b0;
`ifdef MC_MEM_ALIGN_CHK_EN
        e = (addr % 4) != 0;
`endif
        if (!e) begin
            if (mw) m_mem[idx] = wd;
            else begin
                m_mdr = m_mem[idx];
                if (irw) m_ir = m_mem[idx];
            end
        end
    endtask

    // Monitor: every ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.ready === 1'b1) begin
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ready: got ready at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("ready_cycle", 32'(cyc), 32'(e.cyc));
                check("err", {31'b0, bus.err}, {31'b0, e.err});
                check("instr", bus.instr, e.instr);
                check("mdr", bus.mdr, e.mdr);
            end
        end
    end

    task automatic access(input bit iord, input bit mw, input bit irw,
                          input logic [31:0] addr, input logic [31:0] wd);
        bit   e;
        exp_t x;
        @(negedge clk);
        bus.req      = 1'b1;
        bus.iord     = iord;
        bus.memwrite = mw;
        bus.irwrite  = irw;
        bus.wd       = wd;
        bus.pc       = iord ? $urandom : addr;
        bus.aluout   = iord ? addr : $urandom;
        model(mw, irw, addr, wd, e);
        x.err   = e;
        x.instr = m_ir;
        x.mdr   = m_mdr;
        x.cyc   = cyc + W + 2;
        sbq.push_back(x);
        @(negedge clk);
        bus.req      = 1'b0;
        bus.iord     = $urandom;
        bus.memwrite = $urandom;
        bus.irwrite  = $urandom;
        bus.pc       = $urandom;
        bus.aluout   = $urandom;
        bus.wd       = $urandom;
        for (int i = 0; i < 40 && bus.ready !== 1'b1; i++) @(negedge clk);
        if (bus.ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got no ready expected one within 40 cycles");
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, {31'b0, bus.ready}, 32'd0);
        check({tag, "_busy"},  {31'b0, bus.busy},  32'd0);
        check({tag, "_err"},   {31'b0, bus.err},   32'd0);
        check({tag, "_instr"}, bus.instr, 32'd0);
        check({tag, "_mdr"},   bus.mdr,   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int n, idle;
        bus.req = 1'b0; bus.iord = 1'b0; bus.memwrite = 1'b0;
        bus.irwrite = 1'b0; bus.pc = '0; bus.aluout = '0; bus.wd = '0;
        #2;
        check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) access(1, 1, 0, 32'(i * 4), $urandom);

        // Instruction fetch through pc with IR load.
        access(1, 1, 0, 32'h0, 32'h2008_0005);
        access(0, 0, 1, 32'h0, 32'h0);

        // Reset during WAIT of a write aborts it.
        access(1, 1, 0, 32'hC, 32'hA5A5_A5A5);
        @(negedge clk);
        bus.req = 1'b1; bus.iord = 1'b1; bus.memwrite = 1'b1;
        bus.aluout = 32'hC; bus.wd = 32'h1111_1111;
        @(negedge clk);
        bus.req = 1'b0;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        m_ir = '0;
        m_mdr = '0;
        access(1, 0, 0, 32'hC, 32'h0);

        // Store then load without IR update.
        access(0, 0, 1, 32'h0, 32'h0);
        access(1, 1, 0, 32'h10, 32'hDEAD_BEEF);
        access(1, 0, 0, 32'h10, 32'h0);

        // Wrap-around at DEPTH*4 bytes.
        access(1, 1, 0, 32'h400, 32'h1234);
        access(1, 0, 0, 32'h0, 32'h0);

        // Misaligned store to word 4, then read word 4.
        access(1, 1, 0, 32'h12, 32'h0BAD_F00D);
        access(1, 0, 0, 32'h10, 32'h0);
        access(1, 0, 1, 32'h13, 32'h0);

        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            a = 32'(($urandom % 4) * DEPTH * 4) + 32'(($urandom % 16) * 4);
            if ($urandom % 4 == 0) a = a + 32'($urandom % 4);
            access($urandom % 2, $urandom % 2, $urandom % 2, a, $urandom);
        end

        // req held high: back-to-back reads, one idle cycle between.
        @(negedge clk);
        bus.req = 1'b1; bus.iord = 1'b1; bus.memwrite = 1'b0;
        bus.irwrite = 1'b1; bus.aluout = 32'h10;
        for (int k = 0; k < 4; k++) begin
            bit   e;
            exp_t x;
            model(1'b0, 1'b1, 32'h10, 32'h0, e);
            x.err = e; x.instr = m_ir; x.mdr = m_mdr;
            x.cyc = cyc + W + 2 + k * (W + 3);
            sbq.push_back(x);
        end
        n = 0;
        idle = 0;
        for (int i = 0; i < 100 && n < 4; i++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) n++;
            else if (bus.busy === 1'b0 && n >= 1) idle++;
        end
        bus.req = 1'b0;
        check("held_ready_pulses", 32'(n), 32'd4);
        check("held_idle_cycles", 32'(idle), 32'd3);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
